// File: rtl/rom_port_arbiter_pkg.sv
// Shared LSU definitions: port ids, FSM states and response tags
// for the ROM port arbiter and later RAM port sharing.
package rom_port_arbiter_pkg;

  localparam logic [15:0] ROM_BASE_DEF = 16'h8000;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_L = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int TAG_W = 3;

  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } tag_t;

  function automatic logic in_win(
    input logic [15:0] a,
    input logic [15:0] base
  );
    return a >= base;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr.sv
// Two-request round-robin grant; the priority pointer flips
// to the other port whenever a grant is accepted.
import rom_port_arbiter_pkg::*;

module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // Port that wins a tie; fetch first out of reset.
  logic r_prio;

  assign o_gnt[0] = i_en & i_req[0]
                  & (~i_req[1] | (r_prio == PORT_F));
  assign o_gnt[1] = i_en & i_req[1]
                  & (~i_req[0] | (r_prio == PORT_L));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= PORT_F;
    end else if (|o_gnt) begin
      r_prio <= o_gnt[0];
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the LSU ROM read port between fetch and load with
// round-robin grants, short bursts and fixed-latency returns.
import rom_port_arbiter_pkg::*;

module rom_port_arbiter #(
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEF,
  parameter int          ROM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [15:0] f_addr,
  input  logic [1:0]  f_len,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [15:0] l_addr,
  input  logic [1:0]  l_len,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  output logic        f_rsp_err,
  output logic        l_rsp_valid,
  output logic [31:0] l_rsp_data,
  output logic        l_rsp_err,
  output logic [15:0] rom_a,
  output logic        rom_re,
  input  logic [7:0]  rom_q0,
  input  logic [7:0]  rom_q1,
  input  logic [7:0]  rom_q2,
  input  logic [7:0]  rom_q3
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_gnt;
  logic        w_hs;
  logic        w_issue;
  logic [15:0] w_iaddr;
  logic        w_iowner;
  logic        w_inwin;
  logic [1:0]  w_ilen;
  tag_t        w_tag0;
  tag_t        w_tout;

  logic [15:0] r_addr;
  logic [1:0]  r_cnt;
  logic        r_owner;
  logic [15:0] r_rom_a;
  logic        r_rom_re;
  tag_t        r_tag [ROM_LAT+1];
  logic        r_rsp_valid;
  logic        r_rsp_owner;
  logic        r_rsp_err;
  logic [31:0] r_rsp_data;

  rr_arbiter2 u_arb (
    .i_clk (clk),
    .i_rst (rst),
    .i_req ({l_valid, f_valid}),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt)
  );

  assign w_hs    = |w_gnt;
  assign f_ready = w_gnt[0];
  assign l_ready = w_gnt[1];
  assign w_ilen  = w_gnt[1] ? l_len : f_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_iaddr  = r_addr;
    w_iowner = r_owner;
    unique case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_issue  = 1'b1;
          w_iowner = w_gnt[1];
          w_iaddr  = w_gnt[1] ? l_addr : f_addr;
          if (w_ilen != 2'd0) begin
            w_next = BURST;
          end
        end
      end
      BURST: begin
        w_issue = 1'b1;
        if (r_cnt == 2'd1) begin
          w_next = IDLE;
        end
      end
    endcase
  end

  assign w_inwin = in_win(w_iaddr, ROM_BASE);

  // Out-of-window beats never touch the ROM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_cnt    <= '0;
      r_owner  <= PORT_F;
      r_rom_a  <= '0;
      r_rom_re <= 1'b0;
    end else begin
      r_rom_re <= w_issue & w_inwin;
      if (w_issue & w_inwin) begin
        r_rom_a <= w_iaddr;
      end
      if (r_state == IDLE && w_hs) begin
        r_addr  <= w_iaddr + 16'd4;
        r_cnt   <= w_ilen;
        r_owner <= w_iowner;
      end else if (r_state == BURST) begin
        r_addr <= r_addr + 16'd4;
        r_cnt  <= r_cnt - 2'd1;
      end
    end
  end

  assign rom_a  = r_rom_a;
  assign rom_re = r_rom_re;

  assign w_tag0 = {w_issue, w_iowner, ~w_inwin};
  assign w_tout = r_tag[ROM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag0;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= PORT_F;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_tout.valid;
      r_rsp_owner <= w_tout.owner;
      r_rsp_err   <= w_tout.valid & w_tout.err;
      r_rsp_data  <= (w_tout.valid & ~w_tout.err)
                   ? {rom_q3, rom_q2, rom_q1, rom_q0}
                   : '0;
    end
  end

  assign f_rsp_valid = r_rsp_valid & (r_rsp_owner == PORT_F);
  assign l_rsp_valid = r_rsp_valid & (r_rsp_owner == PORT_L);
  assign f_rsp_err   = r_rsp_err & (r_rsp_owner == PORT_F);
  assign l_rsp_err   = r_rsp_err & (r_rsp_owner == PORT_L);
  assign f_rsp_data  = (r_rsp_owner == PORT_F) ? r_rsp_data : '0;
  assign l_rsp_data  = (r_rsp_owner == PORT_L) ? r_rsp_data : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a cycle model
// and a response scoreboard.
module tb_rom_port_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic        l_valid = 1'b0;
  logic [15:0] f_addr = '0;
  logic [15:0] l_addr = '0;
  logic [1:0]  f_len = '0;
  logic [1:0]  l_len = '0;
  logic        f_ready, l_ready;
  logic        f_rsp_valid, l_rsp_valid;
  logic [31:0] f_rsp_data, l_rsp_data;
  logic        f_rsp_err, l_rsp_err;
  logic [15:0] rom_a;
  logic        rom_re;
  logic [7:0]  rom_q0, rom_q1, rom_q2, rom_q3;
  logic [31:0] q_r = '0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_ready(f_ready),
    .f_addr(f_addr), .f_len(f_len),
    .l_valid(l_valid), .l_ready(l_ready),
    .l_addr(l_addr), .l_len(l_len),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
    .l_rsp_err(l_rsp_err),
    .rom_a(rom_a), .rom_re(rom_re),
    .rom_q0(rom_q0), .rom_q1(rom_q1),
    .rom_q2(rom_q2), .rom_q3(rom_q3)
  );

  function automatic logic [31:0] romd(input logic [15:0] a);
    return {a[15:8] ^ 8'hA5, a[7:0] + 8'h11, a[15:8], a[7:0]};
  endfunction

  // One-cycle ROM behind the arbiter.
  always @(posedge clk) if (rom_re) q_r <= romd(rom_a);
  assign rom_q0 = q_r[7:0];
  assign rom_q1 = q_r[15:8];
  assign rom_q2 = q_r[23:16];
  assign rom_q3 = q_r[31:24];

  typedef struct {
    int          due;
    logic        port;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  int          cyc = 0;
  int          ncmp = 0;
  int          nerr = 0;
  logic        m_busy = 0, m_prio = 0, m_owner = 0;
  logic        m_re = 0, m_gf = 0, m_gl = 0;
  logic [15:0] m_addr = '0, m_a = '0;
  logic [1:0]  m_cnt = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic cycle();
    logic        iss;
    logic [15:0] ia;
    logic        io;
    exp_t        e;
    #1;
    m_gf = !m_busy && f_valid && (!l_valid || m_prio == 1'b0);
    m_gl = !m_busy && l_valid && (!f_valid || m_prio == 1'b1);
    if (!rst) begin
      chk("f_ready", 32'(f_ready), 32'(m_gf));
      chk("l_ready", 32'(l_ready), 32'(m_gl));
    end
    iss = 1'b0;
    ia  = m_addr;
    io  = m_owner;
    if (rst) begin
      m_busy = 0; m_prio = 0; m_owner = 0;
      m_a = '0; m_re = 0;
      sbq.delete();
    end else begin
      if (m_gf || m_gl) begin
        iss = 1'b1;
        io = m_gl;
        ia = m_gl ? l_addr : f_addr;
        m_prio = ~io;
        m_owner = io;
        m_cnt = m_gl ? l_len : f_len;
        m_addr = ia + 16'd4;
        m_busy = (m_cnt != 2'd0);
      end else if (m_busy) begin
        iss = 1'b1;
        m_addr = m_addr + 16'd4;
        m_cnt = m_cnt - 2'd1;
        m_busy = (m_cnt != 2'd0);
      end
      m_re = iss && (ia >= 16'h8000);
      if (m_re) m_a = ia;
      if (iss)
        sbq.push_back('{due: cyc + LAT + 2, port: io,
                        err: (ia < 16'h8000),
                        data: (ia >= 16'h8000) ? romd(ia) : 32'h0});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rom_re", 32'(rom_re), 32'(m_re));
    chk("rom_a", 32'(rom_a), 32'(m_a));
    chk("rsp_excl", 32'(f_rsp_valid & l_rsp_valid), 32'h0);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("f_rsp_valid", 32'(f_rsp_valid), 32'(e.port == 1'b0));
      chk("l_rsp_valid", 32'(l_rsp_valid), 32'(e.port == 1'b1));
      chk("rsp_data", e.port ? l_rsp_data : f_rsp_data, e.data);
      chk("rsp_err", 32'(e.port ? l_rsp_err : f_rsp_err), 32'(e.err));
    end else begin
      chk("f_rsp_idle", 32'(f_rsp_valid), 32'h0);
      chk("l_rsp_idle", 32'(l_rsp_valid), 32'h0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sbq.size() > 0; i++) cycle();
    chk("drain_left", 32'(sbq.size()), 32'h0);
    cycle();
  endtask

  task automatic all_zero(input string tag);
    #1;
    chk({tag, "_ready"}, 32'({f_ready, l_ready}), 32'h0);
    chk({tag, "_rspv"}, 32'({f_rsp_valid, l_rsp_valid}), 32'h0);
    chk({tag, "_err"}, 32'({f_rsp_err, l_rsp_err}), 32'h0);
    chk({tag, "_fdat"}, f_rsp_data, 32'h0);
    chk({tag, "_ldat"}, l_rsp_data, 32'h0);
    chk({tag, "_rom"}, 32'({rom_a, rom_re}), 32'h0);
  endtask

  initial begin
    logic [7:0] gseq;
    int         n;
    logic       lr;

    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    all_zero("reset");
    cycle();

    f_valid = 1; f_addr = 16'h8000; f_len = 0;
    cycle();
    f_valid = 0;
    drain();

    rst = 1; cycle(); rst = 0;
    f_valid = 1; f_addr = 16'h8000; f_len = 0;
    l_valid = 1; l_addr = 16'h8004; l_len = 0;
    gseq = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      gseq = {gseq[5:0], l_ready, f_ready};
      cycle();
    end
    chk("grant_seq", 32'(gseq), 32'h66);
    f_valid = 0; l_valid = 0;
    drain();

    l_valid = 1; l_addr = 16'd10; l_len = 0;
    cycle();
    l_valid = 0;
    drain();

    f_valid = 1; f_addr = 16'hFFF8; f_len = 3;
    cycle();
    f_valid = 0;
    drain();

    f_valid = 1; f_addr = 16'h8000; f_len = 3;
    cycle();
    f_valid = 0;
    l_valid = 1; l_addr = 16'h8010; l_len = 0;
    n = 0;
    lr = 0;
    while (!lr && n < 8) begin
      #1;
      lr = l_ready;
      cycle();
      if (!lr) n++;
    end
    chk("l_blocked", 32'(n), 32'd3);
    l_valid = 0;
    drain();

    f_valid = 1; f_addr = 16'h8000; f_len = 3;
    cycle();
    f_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    all_zero("midrst");
    for (int i = 0; i < 4; i++) cycle();
    l_valid = 1; l_addr = 16'h9000; l_len = 1;
    cycle();
    l_valid = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
